// File: rtl/plp_mm_pkg.sv
// ============================================================================
// Module : plp_mm_pkg
// Desc   : Default memory-map tables, FSM state and error cause codes for
//          mm_fabric.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package plp_mm_pkg;

  localparam int MM_SLOTS = 12;

  // Slot 0 in the low word: rom, ram, uart..pmc (0xf0000000 + n*1MB), sseg.
  localparam logic [MM_SLOTS*32-1:0] MM_BASE = {
    32'hf0a0_0000, 32'hf080_0000, 32'hf070_0000, 32'hf060_0000,
    32'hf050_0000, 32'hf040_0000, 32'hf030_0000, 32'hf020_0000,
    32'hf010_0000, 32'hf000_0000, 32'h1000_0000, 32'h0000_0000
  };

  localparam logic [MM_SLOTS*32-1:0] MM_MASK = {
    {10{32'hfff0_0000}}, 32'hff00_0000, 32'hfff0_0000
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } mm_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_UNMAPPED = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } mm_cause_e;

  function automatic int mm_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mm_region_dec.sv
// ============================================================================
// Module : mm_region_dec
// Desc   : Combinational base/mask region match; lowest matching slot wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mm_region_dec
  import plp_mm_pkg::*;
#(
  parameter int                         NUM_SLAVES  = MM_SLOTS,
  parameter int                         IDX_W       = 4,
  parameter logic [NUM_SLAVES*32-1:0]   REGION_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0]   REGION_MASK = '0
) (
  input  logic [31:0]      i_addr,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  logic [NUM_SLAVES-1:0] w_match;

  generate
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
      assign w_match[g] = ((i_addr & REGION_MASK[g*32 +: 32]) == REGION_BASE[g*32 +: 32]);
    end
  endgenerate

  // Walk downwards so the lowest matching index is the last one written.
  always_comb begin
    o_hit = |w_match;
    o_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mm_fabric.sv
// ============================================================================
// Module : mm_fabric
// Desc   : Registered memory-map fabric: region decode, req/ack slave handshake
//          with timeout. Optional error log enabled by defining MM_ERR_LOG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mm_fabric
  import plp_mm_pkg::*;
#(
  parameter int                         NUM_SLAVES  = 12,
  parameter int                         DATA_W      = 32,
  parameter logic [NUM_SLAVES*32-1:0]   REGION_BASE = MM_BASE,
  parameter logic [NUM_SLAVES*32-1:0]   REGION_MASK = MM_MASK,
  parameter int                         TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [31:0]                  m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_we,
  output logic [31:0]                  s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  output logic [31:0]                  err_addr,
  output logic [1:0]                   err_cause,
  output logic                         err_valid,
  input  logic                         err_clr
);

  localparam int               IDX_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int               CNT_W     = mm_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

  mm_state_e          r_state;
  logic [31:0]        r_addr;
  logic               r_we;
  logic [DATA_W-1:0]  r_wdata;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic               w_ack;
  logic               w_tmo;
  logic [DATA_W-1:0]  w_rdata;

  mm_region_dec #(
    .NUM_SLAVES  (NUM_SLAVES),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_dec (
    .i_addr (r_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  // Only the selected slave's ack and data are looked at.
  assign w_ack   = s_ack[r_idx];
  assign w_rdata = s_rdata[r_idx*DATA_W +: DATA_W];
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == TMO_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      m_rdata <= '0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      s_sel   <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      m_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (m_req) begin
            r_addr  <= m_addr;
            r_we    <= m_we;
            r_wdata <= m_wdata;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_hit) begin
            r_idx   <= w_idx;
            s_sel   <= NUM_SLAVES'(1) << w_idx;
            s_we    <= r_we;
            s_addr  <= r_addr & ~REGION_MASK[w_idx*32 +: 32];
            s_wdata <= r_wdata;
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end else begin
            m_ack   <= 1'b1;
            m_err   <= 1'b1;
            m_rdata <= '0;
            r_state <= ST_RESP;
          end
        end
        ST_WAIT: begin
          // A same-cycle ack takes precedence over the timeout.
          if (w_ack || w_tmo) begin
            s_sel   <= '0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            m_ack   <= 1'b1;
            m_err   <= ~w_ack;
            m_rdata <= (w_ack && !r_we) ? w_rdata : '0;
            r_state <= ST_RESP;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MM_ERR_LOG_EN
  logic       w_err_evt;
  logic [1:0] w_err_cause;

  assign w_err_evt   = ((r_state == ST_DECODE) && !w_hit) ||
                       ((r_state == ST_WAIT) && !w_ack && w_tmo);
  assign w_err_cause = (r_state == ST_DECODE) ? CAUSE_UNMAPPED : CAUSE_TIMEOUT;

  // A new error beats a same-cycle clear so it is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_cause <= '0;
    end else if (w_err_evt && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_addr  <= r_addr;
      err_cause <= w_err_cause;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_cause <= '0;
    end
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = err_clr;
  assign err_valid    = 1'b0;
  assign err_addr     = '0;
  assign err_cause    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mm_fabric.sv
// ============================================================================
// Module : tb_mm_fabric
// Desc   : Randomised self-checking bench for mm_fabric against a map/latency
//          model. Build with MM_ERR_LOG_EN to exercise the error log.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mm_fabric;

  localparam int NS = 12;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef MM_ERR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               m_req, m_we, m_ack, m_err;
  logic [31:0]        m_addr, s_addr, err_addr;
  logic [DW-1:0]      m_wdata, m_rdata, s_wdata;
  logic [NS-1:0]      s_sel, s_ack;
  logic               s_we, err_valid, err_clr;
  logic [NS*DW-1:0]   s_rdata;
  logic [1:0]         err_cause;

  always #5 clk = ~clk;

  mm_fabric #(.NUM_SLAVES(NS), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .err_addr(err_addr),
    .err_cause(err_cause), .err_valid(err_valid), .err_clr(err_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory map: rom, ram, uart..pmc, sseg.
  logic [31:0] tb_base [NS] = '{32'h0000_0000, 32'h1000_0000, 32'hf000_0000, 32'hf010_0000,
                                32'hf020_0000, 32'hf030_0000, 32'hf040_0000, 32'hf050_0000,
                                32'hf060_0000, 32'hf070_0000, 32'hf080_0000, 32'hf0a0_0000};
  logic [31:0] tb_mask [NS] = '{32'hfff0_0000, 32'hff00_0000, 32'hfff0_0000, 32'hfff0_0000,
                                32'hfff0_0000, 32'hfff0_0000, 32'hfff0_0000, 32'hfff0_0000,
                                32'hfff0_0000, 32'hfff0_0000, 32'hfff0_0000, 32'hfff0_0000};

  bit          lg_valid = 1'b0;
  logic [31:0] lg_addr  = '0;
  logic [1:0]  lg_cause = '0;

  function automatic int ref_slot(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if ((a & tb_mask[i]) == tb_base[i]) return i;
    return -1;
  endfunction

  // One master access with a slave that acks on WAIT cycle ack_at (> TO = never).
  task automatic do_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rd, input bit stray,
                           input bit clr_race, input string nm);
    int slot, cyc, waits, exp_wait, exp_lat;
    bit exp_err, done;
    logic [31:0] exp_rd;
    logic [1:0]  cause;
    slot = ref_slot(a);
    for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = $urandom;
    if (slot < 0)          begin exp_wait = 0;      exp_err = 1'b1; cause = 2'b01; end
    else if (ack_at > TO)  begin exp_wait = TO + 1; exp_err = 1'b1; cause = 2'b10; end
    else                   begin exp_wait = ack_at + 1; exp_err = 1'b0; cause = 2'b00; end
    exp_lat = 2 + exp_wait;
    exp_rd  = (exp_err || we) ? 32'h0 : rd;
    m_req = 1'b1; m_we = we; m_addr = a; m_wdata = wd;
    cyc = 0; waits = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      s_ack   = '0;
      err_clr = clr_race && (cyc == exp_lat - 1);
      n_cmp++;
      if (m_ack) begin
        done = 1'b1; m_req = 1'b0;
        if (cyc != exp_lat || m_err !== exp_err || m_rdata !== exp_rd || s_sel !== '0) begin
          n_bad++;
          $display("FAIL %s resp: lat=%0d err=%b rdata=%h sel=%h, required lat=%0d err=%b rdata=%h sel=0",
                   nm, cyc, m_err, m_rdata, s_sel, exp_lat, exp_err, exp_rd);
        end
      end else if (s_sel != '0) begin
        if (slot < 0 || s_sel !== (NS'(1) << slot) || s_we !== we ||
            s_addr !== (a & ~tb_mask[slot]) || s_wdata !== wd) begin
          n_bad++;
          $display("FAIL %s slave: sel=%h we=%b addr=%h wdata=%h, required slot=%0d we=%b addr=%h wdata=%h",
                   nm, s_sel, s_we, s_addr, s_wdata, slot, we,
                   (slot < 0) ? 32'h0 : (a & ~tb_mask[slot]), wd);
        end
        if (slot >= 0 && waits == ack_at) begin
          s_ack[slot] = 1'b1;
          s_rdata[slot*DW +: DW] = rd;
        end
        if (stray && slot != 2) s_ack[2] = 1'b1;
        waits++;
      end else if (cyc != 1) begin
        n_bad++;
        $display("FAIL %s idle: no sel/ack at cycle %0d, required activity after cycle 1", nm, cyc);
      end
    end
    s_ack = '0; err_clr = 1'b0; m_req = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no m_ack within 20 cycles, required at %0d", nm, exp_lat);
    end
    n_cmp++;
    if (waits != exp_wait) begin
      n_bad++;
      $display("FAIL %s wait_len: sel held %0d cycles, required %0d", nm, waits, exp_wait);
    end
    if (exp_err && (clr_race || !lg_valid)) begin
      lg_valid = 1'b1; lg_addr = a; lg_cause = cause;
    end
    n_cmp++;
    if (err_valid !== (LOG_EN & lg_valid) || err_addr !== (LOG_EN ? lg_addr : 32'h0) ||
        err_cause !== (LOG_EN ? lg_cause : 2'b00)) begin
      n_bad++;
      $display("FAIL %s log: valid=%b addr=%h cause=%b, required valid=%b addr=%h cause=%b",
               nm, err_valid, err_addr, err_cause, LOG_EN & lg_valid,
               LOG_EN ? lg_addr : 32'h0, LOG_EN ? lg_cause : 2'b00);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    s_ack = '0; s_rdata = '0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({m_ack, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata, err_addr, err_cause, err_valid} !== '0) begin
        n_bad++;
        $display("FAIL reset_%0d: ack=%b err=%b rdata=%h sel=%h we=%b addr=%h log=%b, required all 0",
                 k, m_ack, m_err, m_rdata, s_sel, s_we, s_addr, err_valid);
      end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_read();
    do_access(32'h1000_0123, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, "read_ram");
  endtask

  task automatic test_write();
    do_access(32'hf020_0000, 1'b1, 32'h0000_00A5, 0, 32'h5555_AAAA, 1'b0, 1'b0, "write_gpio");
  endtask

  task automatic test_unmapped();
    do_access(32'h2000_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0, "unmapped_1");
    do_access(32'hf0b0_0000, 1'b1, 32'h7, 0, 32'h0, 1'b0, 1'b0, "unmapped_2");
  endtask

  task automatic test_log_clear();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    lg_valid = 1'b0; lg_addr = '0; lg_cause = '0;
    n_cmp++;
    if (err_valid !== 1'b0 || err_addr !== 32'h0 || err_cause !== 2'b00) begin
      n_bad++;
      $display("FAIL log_clear: valid=%b addr=%h cause=%b, required 0/0/0", err_valid, err_addr, err_cause);
    end
  endtask

  task automatic test_timeout();
    do_access(32'hf000_0010, 1'b0, 32'h0, TO + 1, 32'h1111_2222, 1'b0, 1'b0, "timeout");
    do_access(32'h1000_0040, 1'b0, 32'h0, TO, 32'hCAFE_F00D, 1'b1, 1'b0, "ack_last_cycle");
    do_access(32'h1000_0080, 1'b0, 32'h0, 2, 32'h0BAD_CAFE, 1'b1, 1'b0, "stray_ack");
    do_access(32'h3000_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b1, "clr_race");
  endtask

  task automatic test_back_to_back();
    int acks[$];
    logic [31:0] rd;
    rd = 32'h1234_5678;
    s_rdata = '0;
    s_rdata[0 +: DW] = rd;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0100;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); @(negedge clk);
      s_ack = s_sel;
      if (m_ack) begin
        acks.push_back(c);
        n_cmp++;
        if (m_rdata !== rd || m_err !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_data: rdata=%h err=%b, required %h/0", m_rdata, m_err, rd);
        end
        if (acks.size() == 2) m_req = 1'b0;
      end
    end
    s_ack = '0;
    n_cmp++;
    if (!((acks.size() == 2) ? (acks[0] == 3 && acks[1] == 7) : 1'b0)) begin
      n_bad++;
      $display("FAIL b2b_period: %0d acks first=%0d, required 2 acks at cycles 3 and 7",
               acks.size(), (acks.size() > 0) ? acks[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    bit saw_ack;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1000_0200;
    c = 0;
    while (s_sel == '0 && c < 6) begin @(posedge clk); @(negedge clk); c++; end
    n_cmp++;
    if (s_sel == '0) begin
      n_bad++;
      $display("FAIL rst_mid_wait: sel=0 after %0d cycles, required WAIT by cycle 2", c);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (s_sel !== '0 || m_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_async: sel=%h ack=%b, required 0/0", s_sel, m_ack);
    end
    m_req = 1'b0;
    lg_valid = 1'b0; lg_addr = '0; lg_cause = '0;
    #1 rst = 1'b0;
    saw_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m_ack) saw_ack = 1'b1;
    end
    n_cmp++;
    if (saw_ack) begin
      n_bad++;
      $display("FAIL rst_mid_noack: m_ack seen=1, required 0");
    end
    do_access(32'h1000_0204, 1'b0, 32'h0, 1, 32'h4242_4242, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int slot;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom & 32'hffff_fffc;
      end else begin
        slot = $urandom_range(0, NS - 1);
        a = tb_base[slot] | ($urandom & ~tb_mask[slot] & 32'hffff_fffc);
      end
      do_access(a, 1'($urandom), $urandom, $urandom_range(0, TO + 1), $urandom,
                ($urandom_range(0, 3) == 0), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_log_clear();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
